rtn_chnl_rob: RTL and testbench
===============================

# rtn_chnl_rob

Per-channel return reorder buffer sitting directly downstream of one `rtn_xbar_core` channel output (`u_channel_N_rsp_*`); one instance per channel. The channel issues reads to banks in program order, but responses from different banks return through the crossbar out of order. This block records the issue-order bank ID sequence, buffers responses per bank, and releases them to the channel consumer strictly in issue order.

## Interface
- `DATA_W`, 128, response payload width
- `BANK_NUM`, 4, number of banks
- `BANK_ID_W`, 2, bank ID width
- `ORD_DEPTH`, 16, order-queue entries (power of 2)
- `BANK_FIFO_DEPTH`, 4, per-bank response FIFO entries (power of 2)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `ord_valid`  in  1  request issued; record its bank
- `ord_ready`  out  1  order queue can accept
- `ord_bank_id`  in  BANK_ID_W  bank the request was issued to
- `u_rsp_valid`  in  1  response from xbar channel
- `u_rsp_ready`  out  1  response accepted
- `u_rsp_data`  in  DATA_W  response payload
- `u_rsp_bank_id`  in  BANK_ID_W  source bank of response
- `d_rsp_valid`  out  1  in-order response to consumer
- `d_rsp_ready`  in  1  consumer accepts
- `d_rsp_data`  out  DATA_W  payload
- `d_rsp_bank_id`  out  BANK_ID_W  source bank
- `ord_cnt`  out  $clog2(ORD_DEPTH)+1  outstanding orders (queue occupancy)
- `err_unexp`  out  1  one-cycle pulse: response dropped, no pending order for its bank

## Operation
- Order push: `ord_valid & ord_ready` writes `ord_bank_id` to the order queue, increments `pend_cnt[ord_bank_id]`.
- `ord_ready = !order_queue_full`; no pass-through — full queue refuses push even if pop occurs the same cycle.
- Response accept: `u_rsp_valid & u_rsp_ready`; `u_rsp_ready = !bank_fifo_full[u_rsp_bank_id]`.
- Accepted response with `pend_cnt[b] > 0`, or `pend_cnt[b] == 0` with simultaneous order push to same `b`: written to bank FIFO `b`, `pend_cnt[b]` net-updated (push +1, accept −1).
- Accepted response with `pend_cnt[b] == 0` and no same-bank push: dropped, `err_unexp` pulses next cycle, no state change.
- Output: head bank `h` = order-queue head. `d_rsp_valid = !order_queue_empty & !bank_fifo_empty[h]`; `d_rsp_data/bank_id` = head of bank FIFO `h`.
- Pop: `d_rsp_valid & d_rsp_ready` pops order queue and bank FIFO `h`; `ord_cnt` −1.
- Other banks' responses keep accumulating while head bank stalls (head-of-line waits only on its own bank).
- `pend_cnt` width $clog2(ORD_DEPTH)+1; saturation impossible by construction.

## Timing
- Reset (async assert, clocked deassert use): queues/counters cleared; `ord_ready=1`, `u_rsp_ready=1`, `d_rsp_valid=0`, `ord_cnt=0`, `err_unexp=0`. `d_rsp_data/bank_id` don't-care while `d_rsp_valid=0`; storage arrays not reset.
- Reset mid-operation drops all buffered responses and orders; no output valid until new orders+responses arrive.
- Response accepted at edge N appears on `d_rsp_*` after edge N (visible cycle N+1) if its order is at head; no combinational `u_rsp`→`d_rsp` bypass.
- `ord_ready`, `u_rsp_ready`, `d_rsp_valid` depend only on registered state (no combinational path from `*_valid` / `d_rsp_ready`).
- Throughput: one push, one accept, one pop per cycle concurrently.
- Wrap-around: all FIFO pointers carry an extra MSB for full/empty; behaviour identical across wrap.

## Structure
- `mpc_types` adds `RTN_DATA_W`, `RTN_BANK_NUM`, `RTN_BANK_ID_W` and `rtn_rsp_t` struct {`data`, `bank_id`}.
- Sub-module `mpc_sync_fifo` (parameterised width/depth, registered full/empty, async active-high reset): one instance as order queue, `BANK_NUM` instances as bank FIFOs via generate.
- Top holds `pend_cnt` array, head mux, error pulse.

## Test plan
- Orders 2,0,1; responses arrive bank 1 (0xA1), 0 (0xA0), 2 (0xA2) with `d_rsp_ready=1` → output order 0xA2, 0xA0, 0xA1; `ord_cnt` 3→0.
- 16 orders to bank 3 without responses → `ord_ready=0` after 16th; push+pop same cycle while full → push refused.
- 5 orders to bank 0, 5 responses back-to-back, `d_rsp_ready=0` → 5th response sees `u_rsp_ready=0` until one pop.
- Response from bank 1 with no pending order → dropped, `err_unexp=1` for exactly one cycle, `d_rsp_valid` stays 0.
- Order bank 2 and response bank 2 (0x55) in same cycle with `pend_cnt[2]=0` → accepted, 0x55 output next cycle, no error.
- Assert `rst` with 3 buffered responses → outputs at reset values immediately; afterwards order 0 + response 0x77 → single output 0x77.

Source files
------------

// File: rtl/mpc_types.sv
// Shared types for the return path: response payload layout and default sizing.
package mpc_types;

    localparam int RTN_DATA_W    = 128;
    localparam int RTN_BANK_NUM  = 4;
    localparam int RTN_BANK_ID_W = 2;

    typedef struct packed {
        logic [RTN_DATA_W-1:0]    data;
        logic [RTN_BANK_ID_W-1:0] bank_id;
    } rtn_rsp_t;

endpackage

// File: rtl/mpc_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and registered full/empty flags.
module mpc_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr, wptr_n, rptr_n;
    logic         do_push, do_pop;

    // Push is refused while full even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wptr_n = wptr + (AW+1)'(do_push);
        rptr_n = rptr + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
            empty <= (wptr_n == rptr_n);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/rtn_chnl_rob.sv
// Per-channel return reorder buffer: buffers responses per bank and releases
// them in the order the channel issued its requests.
module rtn_chnl_rob
    import mpc_types::*;
#(
    parameter int DATA_W          = RTN_DATA_W,
    parameter int BANK_NUM        = RTN_BANK_NUM,
    parameter int BANK_ID_W       = RTN_BANK_ID_W,
    parameter int ORD_DEPTH       = 16,
    parameter int BANK_FIFO_DEPTH = 4,
    localparam int CNT_W          = $clog2(ORD_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ord_valid,
    output logic                 ord_ready,
    input  logic [BANK_ID_W-1:0] ord_bank_id,
    input  logic                 u_rsp_valid,
    output logic                 u_rsp_ready,
    input  logic [DATA_W-1:0]    u_rsp_data,
    input  logic [BANK_ID_W-1:0] u_rsp_bank_id,
    output logic                 d_rsp_valid,
    input  logic                 d_rsp_ready,
    output logic [DATA_W-1:0]    d_rsp_data,
    output logic [BANK_ID_W-1:0] d_rsp_bank_id,
    output logic [CNT_W-1:0]     ord_cnt,
    output logic                 err_unexp
);

    localparam int ENT_W = DATA_W + BANK_ID_W;

    logic                 oq_full, oq_empty, ord_push, ord_pop;
    logic [BANK_ID_W-1:0] head_bank;
    logic [BANK_NUM-1:0]  b_full, b_empty, b_push, b_pop;
    logic [ENT_W-1:0]     b_rdata [BANK_NUM];
    logic [CNT_W-1:0]     pend_cnt [BANK_NUM];
    logic [ENT_W-1:0]     head_ent;
    logic                 rsp_acc, rsp_keep, same_bank;

    assign ord_ready   = ~oq_full;
    assign ord_push    = ord_valid & ord_ready;
    assign u_rsp_ready = ~b_full[u_rsp_bank_id];
    assign rsp_acc     = u_rsp_valid & u_rsp_ready;
    // A response may be matched by an order pushed in the very same cycle.
    assign same_bank   = ord_push && (ord_bank_id == u_rsp_bank_id);
    assign rsp_keep    = rsp_acc && ((pend_cnt[u_rsp_bank_id] != '0) || same_bank);

    assign d_rsp_valid   = ~oq_empty & ~b_empty[head_bank];
    assign ord_pop       = d_rsp_valid & d_rsp_ready;
    assign head_ent      = b_rdata[head_bank];
    assign d_rsp_data    = head_ent[ENT_W-1:BANK_ID_W];
    assign d_rsp_bank_id = head_ent[BANK_ID_W-1:0];

    mpc_sync_fifo #(.W(BANK_ID_W), .DEPTH(ORD_DEPTH)) u_ord_q (
        .clk   (clk),
        .rst   (rst),
        .push  (ord_push),
        .pop   (ord_pop),
        .wdata (ord_bank_id),
        .rdata (head_bank),
        .full  (oq_full),
        .empty (oq_empty)
    );

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        assign b_push[b] = rsp_keep && (u_rsp_bank_id == BANK_ID_W'(b));
        assign b_pop[b]  = ord_pop && (head_bank == BANK_ID_W'(b));

        mpc_sync_fifo #(.W(ENT_W), .DEPTH(BANK_FIFO_DEPTH)) u_bank_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (b_push[b]),
            .pop   (b_pop[b]),
            .wdata ({u_rsp_data, u_rsp_bank_id}),
            .rdata (b_rdata[b]),
            .full  (b_full[b]),
            .empty (b_empty[b])
        );
    end

    // pend_cnt tracks issued orders whose response has not yet arrived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) pend_cnt[b] <= '0;
            ord_cnt   <= '0;
            err_unexp <= 1'b0;
        end else begin
            for (int b = 0; b < BANK_NUM; b++)
                pend_cnt[b] <= pend_cnt[b]
                             + CNT_W'(ord_push && (ord_bank_id == BANK_ID_W'(b)))
                             - CNT_W'(b_push[b]);
            ord_cnt   <= ord_cnt + CNT_W'(ord_push) - CNT_W'(ord_pop);
            err_unexp <= rsp_acc & ~rsp_keep;
        end
    end

endmodule

// File: tb/tb_rtn_chnl_rob.sv
// Directed bench for rtn_chnl_rob with a queue-based reference model checked every cycle.
module tb_rtn_chnl_rob;
    import mpc_types::*;

    localparam int OQ_D = 16;
    localparam int BQ_D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ord_valid = 1'b0, ord_ready;
    logic [1:0]   ord_bank_id = '0;
    logic         u_rsp_valid = 1'b0, u_rsp_ready;
    logic [127:0] u_rsp_data = '0;
    logic [1:0]   u_rsp_bank_id = '0;
    logic         d_rsp_valid, d_rsp_ready = 1'b0;
    logic [127:0] d_rsp_data;
    logic [1:0]   d_rsp_bank_id;
    logic [4:0]   ord_cnt;
    logic         err_unexp;

    int checks = 0;
    int failures = 0;

    rtn_chnl_rob dut (
        .clk(clk), .rst(rst),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_bank_id(ord_bank_id),
        .u_rsp_valid(u_rsp_valid), .u_rsp_ready(u_rsp_ready),
        .u_rsp_data(u_rsp_data), .u_rsp_bank_id(u_rsp_bank_id),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_bank_id(d_rsp_bank_id),
        .ord_cnt(ord_cnt), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: issue-order queue, per-bank response queues, pending counts.
    int       oq [$];
    rtn_rsp_t bq [4][$];
    int       pend [4];
    logic     m_err = 1'b0;
    logic [127:0] out_log [$];

    always @(posedge clk or posedge rst) begin
        bit push, acc, keep, pop;
        int b;
        if (rst) begin
            oq.delete();
            for (int i = 0; i < 4; i++) begin bq[i].delete(); pend[i] = 0; end
            m_err = 1'b0;
        end else begin
            pop  = (oq.size() > 0) && (bq[oq[0]].size() > 0) && d_rsp_ready;
            push = ord_valid && (oq.size() < OQ_D);
            b    = int'(u_rsp_bank_id);
            acc  = u_rsp_valid && (bq[b].size() < BQ_D);
            keep = acc && (pend[b] > 0 || (push && int'(ord_bank_id) == b));
            m_err = acc && !keep;
            if (pop) begin
                void'(bq[oq[0]].pop_front());
                void'(oq.pop_front());
            end
            if (keep) begin
                bq[b].push_back('{data: u_rsp_data, bank_id: u_rsp_bank_id});
                pend[b]--;
            end
            if (push) begin
                oq.push_back(int'(ord_bank_id));
                pend[int'(ord_bank_id)]++;
            end
        end
    end

    always @(negedge clk) begin
        logic ev;
        ev = (oq.size() > 0) && (bq[oq[0]].size() > 0);
        chk("ord_ready", ord_ready, oq.size() < OQ_D);
        chk("u_rsp_ready", u_rsp_ready, bq[u_rsp_bank_id].size() < BQ_D);
        chk("d_rsp_valid", d_rsp_valid, ev);
        chk("ord_cnt", ord_cnt, oq.size());
        chk("err_unexp", err_unexp, m_err);
        if (ev) begin
            chk("d_rsp_data", d_rsp_data, bq[oq[0]][0].data);
            chk("d_rsp_bank_id", d_rsp_bank_id, oq[0]);
        end
        if (d_rsp_valid && d_rsp_ready) out_log.push_back(d_rsp_data);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle();
        ord_valid = 1'b0;
        u_rsp_valid = 1'b0;
    endtask

    task automatic order(input logic [1:0] b);
        ord_valid = 1'b1; ord_bank_id = b; cyc(1); ord_valid = 1'b0;
    endtask

    task automatic rsp(input logic [1:0] b, input logic [127:0] d);
        u_rsp_valid = 1'b1; u_rsp_bank_id = b; u_rsp_data = d; cyc(1); u_rsp_valid = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_ord_ready", ord_ready, 1);
        chk("rst_u_rsp_ready", u_rsp_ready, 1);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_ord_cnt", ord_cnt, 0);
        chk("rst_err", err_unexp, 0);
        rst = 1'b0;
        cyc(1);

        // Out-of-order return released in issue order
        d_rsp_ready = 1'b1;
        out_log.delete();
        order(2); order(0); order(1);
        chk("t1_ord_cnt3", ord_cnt, 3);
        rsp(1, 128'hA1); rsp(0, 128'hA0); rsp(2, 128'hA2);
        cyc(4);
        chk("t1_n", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("t1_o0", out_log[0], 128'hA2);
            chk("t1_o1", out_log[1], 128'hA0);
            chk("t1_o2", out_log[2], 128'hA1);
        end
        chk("t1_ord_cnt0", ord_cnt, 0);

        // Order queue full; simultaneous push+pop refuses the push
        ord_valid = 1'b1; ord_bank_id = 2'd3;
        cyc(16);
        chk("t2_full_ready", ord_ready, 0);
        chk("t2_cnt16", ord_cnt, 16);
        u_rsp_valid = 1'b1; u_rsp_bank_id = 2'd3; u_rsp_data = 128'h33;
        cyc(1);
        u_rsp_valid = 1'b0;
        chk("t2_pop_valid", d_rsp_valid, 1);
        cyc(1);
        ord_valid = 1'b0;
        chk("t2_cnt15", ord_cnt, 15);
        for (int i = 0; i < 15; i++) rsp(3, 128'h300 + 128'(i));
        cyc(3);
        chk("t2_drained", ord_cnt, 0);

        // Bank FIFO backpressure
        d_rsp_ready = 1'b0;
        out_log.delete();
        for (int i = 0; i < 5; i++) order(0);
        for (int i = 0; i < 4; i++) rsp(0, 128'hB0 + 128'(i));
        u_rsp_valid = 1'b1; u_rsp_bank_id = 2'd0; u_rsp_data = 128'hB4;
        chk("t3_full0", u_rsp_ready, 0);
        cyc(2);
        chk("t3_full1", u_rsp_ready, 0);
        d_rsp_ready = 1'b1;
        cyc(1);
        d_rsp_ready = 1'b0;
        chk("t3_freed", u_rsp_ready, 1);
        cyc(1);
        u_rsp_valid = 1'b0;
        d_rsp_ready = 1'b1;
        cyc(6);
        chk("t3_n", out_log.size(), 5);
        if (out_log.size() == 5)
            for (int i = 0; i < 5; i++) chk("t3_o", out_log[i], 128'hB0 + 128'(i));

        // Unexpected response is dropped with a one-cycle error pulse
        rsp(1, 128'hDE);
        chk("t4_err_hi", err_unexp, 1);
        chk("t4_no_valid", d_rsp_valid, 0);
        cyc(1);
        chk("t4_err_lo", err_unexp, 0);

        // Same-cycle order and response to an idle bank
        ord_valid = 1'b1; ord_bank_id = 2'd2;
        u_rsp_valid = 1'b1; u_rsp_bank_id = 2'd2; u_rsp_data = 128'h55;
        cyc(1);
        idle();
        chk("t5_valid", d_rsp_valid, 1);
        chk("t5_data", d_rsp_data, 128'h55);
        chk("t5_err", err_unexp, 0);
        cyc(2);
        chk("t5_cnt", ord_cnt, 0);

        // Reset while responses are buffered
        d_rsp_ready = 1'b0;
        order(0); order(1); order(2);
        rsp(0, 128'h10); rsp(1, 128'h11); rsp(2, 128'h12);
        chk("t6_pre_valid", d_rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", d_rsp_valid, 0);
        chk("t6_rst_cnt", ord_cnt, 0);
        chk("t6_rst_ord_ready", ord_ready, 1);
        chk("t6_rst_u_ready", u_rsp_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        d_rsp_ready = 1'b1;
        cyc(1);
        chk("t6_post_valid", d_rsp_valid, 0);
        out_log.delete();
        order(0);
        rsp(0, 128'h77);
        cyc(3);
        chk("t6_n", out_log.size(), 1);
        if (out_log.size() == 1) chk("t6_o0", out_log[0], 128'h77);
        chk("t6_cnt", ord_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
